serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor: one shared DIGIT-bit full-adder slice processes a WIDTH-bit operand pair over WIDTH/DIGIT clock cycles, with the carry registered between digits. Subtraction is a + ~b + 1. A start/done handshake and unsigned carry, signed overflow and zero flags wrap the datapath. It is the sequential, width-generic successor to the single-bit full adder and sits behind the ALU sequencer wherever area matters more than latency.

---
 rtl/serial_addsub_if.sv | 26 ++
 rtl/serial_addsub.sv | 109 ++++++++++
 tb/tb_serial_addsub.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, result, carry_out, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one DIGIT-bit adder slice walks a WIDTH-bit
// operand pair LSB digit first, carry registered between digits.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]    K_LAST = KW'(N - 1);
    localparam logic [WIDTH-1:0] DMASK  = ~({WIDTH{1'b1}} << DIGIT);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             accept, last;
    logic [WIDTH-1:0] a_q, b_q, wrk_q, wrk_d;
    logic             cy_q, cy_d;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, ovf_q, zero_q;
    logic [DIGIT:0]   dsum;
    int unsigned      sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                accept  = 1'b1;
            end
            RUN: if (k_q == K_LAST) begin
                state_d = DONE;
                last    = 1'b1;
            end
            DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit k is selected by shifting, then merged back under a sliding mask.
    always_comb begin
        sh    = k_q * DIGIT;
        dsum  = {1'b0, DIGIT'(a_q >> sh)} + {1'b0, DIGIT'(b_q >> sh)}
              + {{DIGIT{1'b0}}, cy_q};
        cy_d  = dsum[DIGIT];
        wrk_d = (wrk_q & ~(DMASK << sh)) | (WIDTH'(dsum[DIGIT-1:0]) << sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            wrk_q    <= '0;
            cy_q     <= 1'b0;
            k_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            a_q  <= bus.a;
            b_q  <= bus.sub ? ~bus.b : bus.b;
            cy_q <= bus.sub;
            k_q  <= '0;
        end else if (state_q == RUN) begin
            wrk_q <= wrk_d;
            cy_q  <= cy_d;
            k_q   <= k_q + KW'(1);
            if (last) begin
                result_q <= wrk_d;
                carry_q  <= cy_d;
                zero_q   <= (wrk_d == '0);
                ovf_q    <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (wrk_d[WIDTH-1] != a_q[WIDTH-1]);
            end
        end
    end

    assign bus.ready     = (state_q != RUN);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: three configurations against an
// arithmetic reference model.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8))  ifA();
    serial_addsub_if #(.WIDTH(8))  ifB();
    serial_addsub_if #(.WIDTH(16)) ifC();

    serial_addsub #(.WIDTH(8),  .DIGIT(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    serial_addsub #(.WIDTH(8),  .DIGIT(4)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
    serial_addsub #(.WIDTH(16), .DIGIT(2)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

    typedef struct packed {
        logic [15:0] res;
        logic        cy;
        logic        ov;
        logic        z;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: plain integer arithmetic, unsigned carry and signed range test.
    function automatic exp_t model(input int w, input longint a, input longint b, input bit sub);
        longint m, half, sa, sb, r, sr;
        exp_t e;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        if (sub) begin
            r    = a - b;
            sr   = sa - sb;
            e.cy = (a >= b);
        end else begin
            r    = a + b;
            sr   = sa + sb;
            e.cy = (r >= m);
        end
        r    = ((r % m) + m) % m;
        e.res = 16'(r);
        e.ov  = (sr < -half) || (sr >= half);
        e.z   = (r == 0);
        return e;
    endfunction

    task automatic set_in(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                          input logic sub);
        if (sel == 0) begin
            ifA.start = st; ifA.a = a; ifA.b = b; ifA.sub = sub;
        end else begin
            ifB.start = st; ifB.a = a; ifB.b = b; ifB.sub = sub;
        end
    endtask

    function automatic exp_t sample(input int sel);
        exp_t g;
        if (sel == 0) g = '{res: {8'h00, ifA.result}, cy: ifA.carry_out, ov: ifA.overflow, z: ifA.zero};
        else          g = '{res: {8'h00, ifB.result}, cy: ifB.carry_out, ov: ifB.overflow, z: ifB.zero};
        return g;
    endfunction

    // Called just after a negedge; runs one 8-bit op over a fixed 14-cycle window.
    task automatic run8(input int sel, input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input int pulse_at, output int lat, output int nbusy, output int ndone,
                        output exp_t got);
        logic bz, dn;
        set_in(sel, 1'b1, a, b, sub);
        lat = 0; nbusy = 0; ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1)
                set_in(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            if (pulse_at != 0 && c == pulse_at)
                set_in(sel, 1'b1, ~a, a ^ b, ~sub);
            if (pulse_at != 0 && c == pulse_at + 1)
                set_in(sel, 1'b0, 8'h00, 8'h00, 1'b0);
            bz = (sel == 0) ? ifA.busy : ifB.busy;
            dn = (sel == 0) ? ifA.done : ifB.done;
            if (bz) nbusy++;
            if (dn) begin
                ndone++;
                if (lat == 0) lat = c;
            end
        end
        got = sample(sel);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifA.start = 0; ifA.sub = 0; ifA.a = '0; ifA.b = '0;
        ifB.start = 0; ifB.sub = 0; ifB.a = '0; ifB.b = '0;
        ifC.start = 0; ifC.sub = 0; ifC.a = '0; ifC.b = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ifA.ready, ifA.busy, ifA.done, ifA.carry_out, ifA.overflow, ifA.zero, ifA.result} !== {1'b1, 13'h0}) begin
            n_errors++;
            $display("FAIL reset_A: got %b expected %b",
                     {ifA.ready, ifA.busy, ifA.done, ifA.carry_out, ifA.overflow, ifA.zero, ifA.result}, {1'b1, 13'h0});
        end
        n_checks++;
        if ({ifC.ready, ifC.busy, ifC.done, ifC.carry_out, ifC.overflow, ifC.zero, ifC.result} !== {1'b1, 21'h0}) begin
            n_errors++;
            $display("FAIL reset_C: got %b expected %b",
                     {ifC.ready, ifC.busy, ifC.done, ifC.carry_out, ifC.overflow, ifC.zero, ifC.result}, {1'b1, 21'h0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ifB.ready, ifB.busy, ifB.done, ifB.result} !== {1'b1, 10'h0}) begin
            n_errors++;
            $display("FAIL reset_B_after_release: got %b expected %b",
                     {ifB.ready, ifB.busy, ifB.done, ifB.result}, {1'b1, 10'h0});
        end
    endtask

    task automatic test_vectors();
        int   sel_t[5] = '{0, 0, 0, 1, 1};
        logic [7:0] a_t[5] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'hFF};
        logic [7:0] b_t[5] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h01};
        logic sub_t[5]     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_t e_t[5] = '{'{res: 16'h02, cy: 1, ov: 0, z: 0},
                         '{res: 16'hFE, cy: 0, ov: 0, z: 0},
                         '{res: 16'h7F, cy: 1, ov: 1, z: 0},
                         '{res: 16'h80, cy: 0, ov: 1, z: 0},
                         '{res: 16'h00, cy: 1, ov: 0, z: 1}};
        int lat, nb, nd, n;
        exp_t g;
        for (int i = 0; i < 5; i++) begin
            n = (sel_t[i] == 0) ? 8 : 2;
            run8(sel_t[i], a_t[i], b_t[i], sub_t[i], 0, lat, nb, nd, g);
            n_checks++;
            if (g !== e_t[i]) begin
                n_errors++;
                $display("FAIL vec%0d_value: got %h expected %h", i, g, e_t[i]);
            end
            n_checks++;
            if (lat !== n + 1 || nb !== n || nd !== 1) begin
                n_errors++;
                $display("FAIL vec%0d_timing: latency %0d busy %0d dones %0d expected %0d %0d 1",
                         i, lat, nb, nd, n + 1, n);
            end
        end
    endtask

    task automatic test_random8();
        int lat, nb, nd, n;
        logic [7:0] a, b;
        logic sub;
        exp_t g, e;
        for (int i = 0; i < 40; i++) begin
            int sel = i % 2;
            n   = (sel == 0) ? 8 : 2;
            a   = 8'($urandom);
            b   = (i % 7 == 3) ? a : 8'($urandom);
            sub = 1'($urandom);
            e   = model(8, longint'(a), longint'(b), sub);
            run8(sel, a, b, sub, 0, lat, nb, nd, g);
            n_checks++;
            if (g !== e || lat !== n + 1 || nd !== 1) begin
                n_errors++;
                $display("FAIL rand8_%0d sel%0d a=%h b=%h sub=%b: got %h lat %0d dones %0d expected %h lat %0d dones 1",
                         i, sel, a, b, sub, g, lat, nd, e, n + 1);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat, nb, nd;
        exp_t g, e;
        e = model(8, 64'h5A, 64'h33, 1'b0);
        run8(0, 8'h5A, 8'h33, 1'b0, 3, lat, nb, nd, g);
        n_checks++;
        if (g !== e || lat !== 9 || nd !== 1 || nb !== 8) begin
            n_errors++;
            $display("FAIL ignore_start: got %h lat %0d busy %0d dones %0d expected %h lat 9 busy 8 dones 1",
                     g, lat, nb, nd, e);
        end
    endtask

    task automatic test_reset_mid_run();
        int ndone, lat, nb, nd;
        exp_t g, e;
        set_in(0, 1'b1, 8'h9C, 8'h21, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ifA.ready, ifA.busy, ifA.done, ifA.carry_out, ifA.overflow, ifA.zero, ifA.result} !== {1'b1, 13'h0}) begin
            n_errors++;
            $display("FAIL reset_mid_run: got %b expected %b",
                     {ifA.ready, ifA.busy, ifA.done, ifA.carry_out, ifA.overflow, ifA.zero, ifA.result}, {1'b1, 13'h0});
        end
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 1) rst_n = 1'b1;
            if (ifA.done) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_errors++;
            $display("FAIL reset_no_done: got %0d done pulses expected 0", ndone);
        end
        e = model(8, 64'hC8, 64'h64, 1'b1);
        run8(0, 8'hC8, 8'h64, 1'b1, 0, lat, nb, nd, g);
        n_checks++;
        if (g !== e || lat !== 9 || nd !== 1) begin
            n_errors++;
            $display("FAIL reset_recover: got %h lat %0d dones %0d expected %h lat 9 dones 1", g, lat, nd, e);
        end
    endtask

    // start held high; new operands presented only in accepting cycles, junk otherwise.
    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e, g;
        logic [15:0] a, b;
        int ops = 0;
        int seen = 0;
        for (int c = 0; c <= 900; c++) begin
            if (c > 0) begin
                n_checks++;
                if (ifC.done !== (c % 9 == 0)) begin
                    n_errors++;
                    $display("FAIL b2b_done_cycle%0d: got %b expected %b", c, ifC.done, (c % 9 == 0));
                end
                if (ifC.done && q.size() > 0) begin
                    e = q.pop_front();
                    g = '{res: ifC.result, cy: ifC.carry_out, ov: ifC.overflow, z: ifC.zero};
                    seen++;
                    n_checks++;
                    if (g !== e) begin
                        n_errors++;
                        $display("FAIL b2b_op%0d: got %h expected %h", seen, g, e);
                    end
                end
            end
            if (c % 9 == 0 && ops < 100) begin
                a = 16'($urandom);
                b = (ops % 11 == 5) ? a : 16'($urandom);
                ifC.start = 1'b1; ifC.a = a; ifC.b = b; ifC.sub = ops[0];
                q.push_back(model(16, longint'(a), longint'(b), ops[0]));
                ops++;
            end else if (c == 900) begin
                ifC.start = 1'b0;
            end else begin
                ifC.a = 16'($urandom); ifC.b = 16'($urandom); ifC.sub = 1'($urandom);
            end
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 100) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d results expected 100", seen);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_random8();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
